// File: rtl/duram_fifo_rd.sv
// Read-side controller for a duram-based FIFO: issues RAM reads, absorbs the
// one-cycle RAM latency in a 2-entry skid buffer and presents a valid/ready stream.
module duram_fifo_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH:0]   Wr_ptr,
    output logic [ADDR_WIDTH:0]   Rd_ptr,
    output logic [ADDR_WIDTH:0]   Rd_level,
    output logic [ADDR_WIDTH-1:0] Ram_addr,
    input  logic [DATA_WIDTH-1:0] Ram_q,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  Dout_valid,
    input  logic                  Dout_ready
);

    logic [ADDR_WIDTH:0]   issue_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr_q;
    logic                  in_flight;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [DATA_WIDTH-1:0] skid_tail;

    logic                  transfer;
    logic                  data_avail;
    logic [1:0]            occupancy;
    logic                  issue;
    logic [1:0]            capture_slot;
    logic [1:0]            skid_count_n;
    logic [DATA_WIDTH-1:0] skid_head_n;
    logic [DATA_WIDTH-1:0] skid_tail_n;

    assign Dout_valid = (skid_count != 2'd0);
    assign Dout       = skid_head;
    assign Ram_addr   = issue_ptr[ADDR_WIDTH-1:0];
    assign Rd_ptr     = rd_ptr_q;
    assign Rd_level   = Wr_ptr - rd_ptr_q;

    assign transfer   = Dout_valid && Dout_ready;
    assign data_avail = (Wr_ptr != issue_ptr);
    assign occupancy  = skid_count + {1'b0, in_flight};

    // A slot freed by this cycle's transfer may be refilled by the word we issue now.
    assign issue = data_avail && !Flush &&
                   ((occupancy < 2'd2) || ((occupancy == 2'd2) && transfer));

    // The captured word lands behind whatever survives this cycle's transfer.
    assign capture_slot = skid_count - {1'b0, transfer};

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        skid_head_n  = skid_head;
        skid_tail_n  = skid_tail;
        skid_count_n = skid_count + {1'b0, in_flight} - {1'b0, transfer};
        if (transfer) begin
            skid_head_n = skid_tail;
        end
        if (in_flight) begin
            if (capture_slot == 2'd0) begin
                skid_head_n = Ram_q;
            end else begin
                skid_tail_n = Ram_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            issue_ptr  <= '0;
            rd_ptr_q   <= '0;
            in_flight  <= 1'b0;
            skid_count <= 2'd0;
            // NOTE: the data entries are reset only because the head drives
            // Dout, whose reset value is visible; Flush leaves them alone.
            skid_head  <= '0;
            skid_tail  <= '0;
        end else if (Flush) begin
            issue_ptr  <= Wr_ptr;
            rd_ptr_q   <= Wr_ptr;
            in_flight  <= 1'b0;
            skid_count <= 2'd0;
        end else begin
            if (issue) begin
                issue_ptr <= issue_ptr + 1'b1;
            end
            if (in_flight) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            in_flight  <= issue;
            skid_count <= skid_count_n;
            skid_head  <= skid_head_n;
            skid_tail  <= skid_tail_n;
        end
    end

endmodule

// File: tb/tb_duram_fifo_rd.sv
// Directed bench for duram_fifo_rd: a behavioural RAM plus an ideal FIFO queue
// supply expected words; all comparisons go through check().
module tb_duram_fifo_rd;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk;
    logic          Reset;
    logic [AW:0]   Wr_ptr;
    logic [AW:0]   Rd_ptr;
    logic [AW:0]   Rd_level;
    logic [AW-1:0] Ram_addr;
    logic [DW-1:0] Ram_q;
    logic          Flush;
    logic [DW-1:0] Dout;
    logic          Dout_valid;
    logic          Dout_ready;

    duram_fifo_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Wr_ptr     (Wr_ptr),
        .Rd_ptr     (Rd_ptr),
        .Rd_level   (Rd_level),
        .Ram_addr   (Ram_addr),
        .Ram_q      (Ram_q),
        .Flush      (Flush),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // RAM port B: registered address, unregistered data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q;
    always @(posedge Clk) ram_addr_q <= Ram_addr;
    assign Ram_q = mem[ram_addr_q];

    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int vcount   = 0;
    int first_v  = -1;
    int last_v   = -1;
    bit wrapped  = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic write_word(input logic [DW-1:0] data);
        mem[Wr_ptr[AW-1:0]] = data;
        exp_q.push_back(data);
        Wr_ptr = Wr_ptr + 1'b1;
    endtask

    task automatic clear_stats();
        vcount  = 0;
        first_v = -1;
        last_v  = -1;
        wrapped = 1'b0;
    endtask

    // Settle, score any transfer in this cycle, advance one clock, then check hold.
    task automatic run_cycle();
        logic          hold;
        logic [DW-1:0] held;
        logic [AW:0]   prev_rd;
        #1;
        hold    = Dout_valid && !Dout_ready && !Flush && !Reset;
        held    = Dout;
        prev_rd = Rd_ptr;
        if (Dout_valid && Dout_ready && !Reset && !Flush) begin
            if (exp_q.size() == 0) check("extra_word", 64'(Dout), 64'hDEAD_0000_0000);
            else check("stream", 64'(Dout), 64'(exp_q.pop_front()));
        end
        if (Dout_valid) begin
            vcount++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        @(posedge Clk);
        #1;
        cyc++;
        if (hold) begin
            check("hold_valid", 64'(Dout_valid), 64'd1);
            check("hold_data", 64'(Dout), 64'(held));
        end
        if (prev_rd == 6'd63 && Rd_ptr == 6'd0) wrapped = 1'b1;
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        Flush      = 1'b0;
        Dout_ready = 1'b0;
        Wr_ptr     = '0;
        exp_q.delete();
        run_cycle();
        run_cycle();
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Flush = 1'b0; Dout_ready = 1'b0; Wr_ptr = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        @(posedge Clk); #1;
        do_reset();

        // Reset state
        check("rst_valid", 64'(Dout_valid), 64'd0);
        check("rst_dout", 64'(Dout), 64'd0);
        check("rst_rd_ptr", 64'(Rd_ptr), 64'd0);
        check("rst_ram_addr", 64'(Ram_addr), 64'd0);
        check("rst_level", 64'(Rd_level), 64'd0);

        // Single word latency
        Dout_ready = 1'b1;
        write_word(32'hA5A5_A5A5);
        #1;
        check("lat_addr_n", 64'(Ram_addr), 64'd0);
        check("lat_level_n", 64'(Rd_level), 64'd1);
        check("lat_valid_n", 64'(Dout_valid), 64'd0);
        run_cycle();
        check("lat_valid_n1", 64'(Dout_valid), 64'd0);
        check("lat_rdptr_n1", 64'(Rd_ptr), 64'd0);
        run_cycle();
        check("lat_valid_n2", 64'(Dout_valid), 64'd1);
        check("lat_dout_n2", 64'(Dout), 64'hA5A5_A5A5);
        check("lat_rdptr_n2", 64'(Rd_ptr), 64'd1);
        check("lat_level_n2", 64'(Rd_level), 64'd0);
        run_cycle();
        check("lat_valid_n3", 64'(Dout_valid), 64'd0);
        check("lat_addr_hold", 64'(Ram_addr), 64'd1);

        // Full preload then drain with ready held high
        do_reset();
        Dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) write_word(32'h1000_0000 + 32'(i));
        #1;
        check("full_level", 64'(Rd_level), 64'd32);
        clear_stats();
        for (int i = 0; i < 40; i++) run_cycle();
        check("full_vcount", 64'(vcount), 64'd32);
        check("full_no_gap", 64'(last_v - first_v), 64'd31);
        check("full_rdptr", 64'(Rd_ptr), 64'd32);
        check("full_level_end", 64'(Rd_level), 64'd0);
        check("full_drained", 64'(exp_q.size()), 64'd0);

        // Streaming across pointer wrap: pointers 32..72, one write per cycle
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            write_word(32'hC000_0000 + 32'(i));
            run_cycle();
        end
        for (int i = 0; i < 10; i++) run_cycle();
        check("wrap_vcount", 64'(vcount), 64'd40);
        check("wrap_no_gap", 64'(last_v - first_v), 64'd39);
        check("wrap_rdptr_wrapped", 64'(wrapped), 64'd1);
        check("wrap_rdptr_end", 64'(Rd_ptr), 64'd8);
        check("wrap_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: 8 words, ready low for 10 cycles
        do_reset();
        for (int i = 0; i < 8; i++) write_word(32'hD000_0000 + 32'(i));
        for (int i = 0; i < 10; i++) run_cycle();
        check("bp_rdptr", 64'(Rd_ptr), 64'd2);
        check("bp_valid", 64'(Dout_valid), 64'd1);
        check("bp_dout", 64'(Dout), 64'hD000_0000);
        check("bp_level", 64'(Rd_level), 64'd6);

        // Random ready toggling with occasional writes, scored against the queue
        for (int i = 0; i < 200; i++) begin
            Dout_ready = 1'($urandom_range(0, 1));
            #1;
            if ($urandom_range(0, 2) == 0 && Rd_level < 6'd32)
                write_word(32'hE000_0000 + 32'(i));
            run_cycle();
        end
        Dout_ready = 1'b1;
        for (int i = 0; i < 60; i++) run_cycle();
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_valid_end", 64'(Dout_valid), 64'd0);
        check("rand_level_end", 64'(Rd_level), 64'd0);

        // Flush with one transfer done and an issue in flight
        do_reset();
        Dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) write_word(32'h5000_0000 + 32'(i));
        run_cycle();
        run_cycle();
        run_cycle();
        check("fl_one_taken", 64'(exp_q.size()), 64'd4);
        Dout_ready = 1'b0;
        Flush      = 1'b1;
        run_cycle();
        Flush = 1'b0;
        exp_q.delete();
        check("fl_valid", 64'(Dout_valid), 64'd0);
        check("fl_rdptr", 64'(Rd_ptr), 64'd5);
        check("fl_level", 64'(Rd_level), 64'd0);
        check("fl_ram_addr", 64'(Ram_addr), 64'd5);
        Dout_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) run_cycle();
        check("fl_no_stale", 64'(vcount), 64'd0);
        write_word(32'h0000_1234);
        for (int i = 0; i < 6; i++) run_cycle();
        check("fl_post_count", 64'(vcount), 64'd1);
        check("fl_post_drained", 64'(exp_q.size()), 64'd0);
        check("fl_post_rdptr", 64'(Rd_ptr), 64'd6);

        // Reset mid-stream with words buffered and in flight
        Dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(32'h6000_0000 + 32'(i));
        run_cycle();
        run_cycle();
        check("mr_valid_before", 64'(Dout_valid), 64'd1);
        Reset  = 1'b1;
        Wr_ptr = '0;
        exp_q.delete();
        run_cycle();
        check("mr_valid", 64'(Dout_valid), 64'd0);
        check("mr_dout", 64'(Dout), 64'd0);
        check("mr_rdptr", 64'(Rd_ptr), 64'd0);
        check("mr_ram_addr", 64'(Ram_addr), 64'd0);
        check("mr_level", 64'(Rd_level), 64'd0);
        Reset      = 1'b0;
        Dout_ready = 1'b1;
        clear_stats();
        for (int i = 0; i < 5; i++) run_cycle();
        check("mr_no_stale", 64'(vcount), 64'd0);
        write_word(32'h0000_BEEF);
        for (int i = 0; i < 5; i++) run_cycle();
        check("mr_post_count", 64'(vcount), 64'd1);
        check("mr_post_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
